// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Feeds one shared decoder per slot, with dead-time, blinking and leading-zero blanking.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lzs_en,
    output logic [4:0]              dec_data,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [4:0]            BLANK    = 5'b01111;
    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]         DEAD     = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE      = NUM_DIGITS'(1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           fcnt;
    logic                    ph;
    logic [5*NUM_DIGITS-1:0] shadow;
    logic [5*NUM_DIGITS-1:0] pend;
    logic                    pend_v;

    logic                    tick;
    logic                    boundary;
    logic                    dead;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   low_mask;
    logic [NUM_DIGITS-1:0]   iszero;
    logic                    zero_run;
    logic                    blink_bit;
    logic [4:0]              cur_code;
    logic [4:0]              eff_code;

    assign tick       = (cnt == CNT_LAST);
    assign boundary   = tick && (idx == IDX_LAST);
    assign dead       = (cnt < DEAD);
    assign sel_onehot = ONE << idx;
    assign low_mask   = sel_onehot - ONE;
    assign blink_bit  = |(blink_mask & sel_onehot);
    // Digits below idx are don't-care; idx and everything above it must be 00000.
    assign zero_run   = &(iszero | low_mask);

    always_comb begin
        cur_code = BLANK;
        iszero   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            iszero[i] = (shadow[5*i +: 5] == 5'b00000);
            if (idx == IW'(i)) begin
                cur_code = shadow[5*i +: 5];
            end
        end
    end

    always_comb begin
        eff_code = cur_code;
        if (blink_bit && ph) begin
            eff_code = BLANK;
        end else if (lzs_en && (idx != '0) && zero_run) begin
            eff_code = BLANK;
        end
    end

    // load/ack: a one-cycle load captures digits_in (latest wins while pending);
    // the buffer swaps only on the frame-boundary tick, signalled by one load_ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            ph         <= 1'b0;
            shadow     <= {NUM_DIGITS{BLANK}};
            pend       <= '0;
            pend_v     <= 1'b0;
            dec_data   <= BLANK;
            anodes     <= '1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_done <= 1'b0;

            if (tick) begin
                cnt <= '0;
                idx <= boundary ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (boundary) begin
                frame_done <= 1'b1;
                if (fcnt == FRM_LAST) begin
                    fcnt <= '0;
                    ph   <= ~ph;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
                if (load) begin
                    shadow   <= digits_in;
                    pend_v   <= 1'b0;
                    load_ack <= 1'b1;
                end else if (pend_v) begin
                    shadow   <= pend;
                    pend_v   <= 1'b0;
                    load_ack <= 1'b1;
                end
            end else if (load) begin
                pend   <= digits_in;
                pend_v <= 1'b1;
            end

            anodes <= dead ? '1 : ~sel_onehot;
            // Latch the code only during dead-time so a lit digit never glitches.
            if (dead) begin
                dec_data <= eff_code;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random traffic, checked
// cycle by cycle against a time-arithmetic model of the scan display.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int SD    = 6;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int FRAME = N * SD;
    localparam int W     = 11;
    localparam logic [4:0] BLANK = 5'b01111;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [5*N-1:0] digits_in = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           lzs_en = 1'b0;
    logic [4:0]     dec_data;
    logic [N-1:0]   anodes;
    logic           load_ack;
    logic           frame_done;

    seven_seg_scan #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .blink_mask(blink_mask), .lzs_en(lzs_en), .dec_data(dec_data),
        .anodes(anodes), .load_ack(load_ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int             errors = 0;
    int             checks = 0;
    int             t = 0;
    int             ack_seen = 0;
    int             fd_seen = 0;
    logic [4:0]     sh_m[N];
    logic [5*N-1:0] pend_m;
    logic           pend_vm;
    logic [4:0]     exp_dec;
    logic [W-1:0]   exp_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, expv, t);
        end
    endtask

    function automatic logic [4:0] eff(input int i, input logic ph);
        logic all_zero;
        if (blink_mask[i] && ph) return BLANK;
        all_zero = 1'b1;
        for (int j = i; j < N; j++) if (sh_m[j] != 5'b00000) all_zero = 1'b0;
        if (lzs_en && i != 0 && all_zero) return BLANK;
        return sh_m[i];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) sh_m[i] = BLANK;
        pend_m  = '0;
        pend_vm = 1'b0;
        exp_dec = BLANK;
    endtask

    // Outputs seen now reflect the cycle t that just ended at the clock edge.
    task automatic check_cycle();
        int           cnt_m, idx_m, f;
        logic         bnd, ph_m, ack;
        logic [N-1:0] an;
        logic [W-1:0] e;
        cnt_m = t % SD;
        idx_m = (t / SD) % N;
        f     = t / FRAME;
        ph_m  = ((f / BF) % 2) == 1;
        bnd   = (t % FRAME) == FRAME - 1;
        an    = (cnt_m < DEAD) ? {N{1'b1}} : ~(4'b0001 << idx_m);
        if (cnt_m < DEAD) exp_dec = eff(idx_m, ph_m);
        ack   = bnd && (load || pend_vm);
        exp_q.push_back({an, exp_dec, ack, bnd});
        if (bnd) begin
            if (load) begin
                for (int i = 0; i < N; i++) sh_m[i] = digits_in[5*i +: 5];
            end else if (pend_vm) begin
                for (int i = 0; i < N; i++) sh_m[i] = pend_m[5*i +: 5];
            end
            pend_vm = 1'b0;
        end else if (load) begin
            pend_m  = digits_in;
            pend_vm = 1'b1;
        end
        e = exp_q.pop_front();
        chk("anodes", 8'(anodes), 8'(e[10:7]));
        chk("dec_data", 8'(dec_data), 8'(e[6:2]));
        chk("load_ack", 8'(load_ack), 8'(e[1]));
        chk("frame_done", 8'(frame_done), 8'(e[0]));
        if (load_ack === 1'b1) ack_seen++;
        if (frame_done === 1'b1) fd_seen++;
        t++;
    endtask

    task automatic step(input logic ld, input logic [5*N-1:0] din);
        load      = ld;
        digits_in = din;
        @(posedge clk);
        #1;
        check_cycle();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, digits_in);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_anodes", 8'(anodes), 8'hF);
        chk("rst_dec", 8'(dec_data), 8'(BLANK));
        chk("rst_ack", 8'(load_ack), 8'h0);
        chk("rst_fd", 8'(frame_done), 8'h0);
    endtask

    // Step until the current cycle is the boundary tick.
    task automatic to_boundary();
        while ((t % FRAME) != FRAME - 1) step(1'b0, digits_in);
    endtask

    function automatic logic [5*N-1:0] rand_digits();
        logic [5*N-1:0] d;
        for (int i = 0; i < N; i++)
            d[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'b00000 : 5'($urandom_range(0, 31));
        return d;
    endfunction

    initial begin
        // 1: reset and idle
        do_reset();
        fd_seen = 0;
        idle(48);
        chk("idle_frame_done_count", 8'(fd_seen), 8'd2);

        // 2: single load mid-frame
        idle(5);
        ack_seen = 0;
        step(1'b1, {5'b00001, 5'b10010, 5'b00011, 5'b00100});
        idle(FRAME * 2);
        chk("single_load_acks", 8'(ack_seen), 8'd1);

        // 3: two loads in one frame, latest wins
        idle(3);
        ack_seen = 0;
        step(1'b1, {5'b00101, 5'b00101, 5'b00101, 5'b00101});
        idle(4);
        step(1'b1, {4{5'b00111}});
        idle(FRAME * 2);
        chk("double_load_acks", 8'(ack_seen), 8'd1);

        // 4: leading-zero suppression
        lzs_en = 1'b1;
        step(1'b1, {5'b00000, 5'b00000, 5'b00101, 5'b00000});
        idle(FRAME * 2);
        step(1'b1, {5'b00000, 5'b10000, 5'b00000, 5'b00000});
        idle(FRAME * 2);
        lzs_en = 1'b0;

        // 5: blinking digit 0
        blink_mask = 4'b0001;
        step(1'b1, {5'b00001, 5'b00010, 5'b00011, 5'b01000});
        idle(FRAME * 8);
        blink_mask = 4'b0000;

        // 6: load exactly on the boundary tick
        to_boundary();
        ack_seen = 0;
        step(1'b1, {5'b00110, 5'b00111, 5'b01000, 5'b01001});
        chk("boundary_load_ack_now", 8'(ack_seen), 8'd1);
        idle(FRAME);

        // reset while a load is pending
        idle(4);
        step(1'b1, {4{5'b00010}});
        idle(3);
        do_reset();
        ack_seen = 0;
        idle(FRAME + 6);
        chk("rst_pending_no_ack", 8'(ack_seen), 8'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) lzs_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) step(1'b1, rand_digits());
            else step(1'b0, digits_in);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan controller that shares the single `seven_seg_dec` 5-bit-code decoder among NUM_DIGITS common-anode digits of the Auto-Shop display. It holds a frame buffer of per-digit 5-bit codes, steps one digit per scan slot, and drives the decoder input and active-low anode enables. It also applies blanking dead-time, blinking and leading-zero suppression. New display contents are accepted through a load/ack handshake and applied only at frame boundaries, so a frame never tears.

## Interface
- `NUM_DIGITS`, 8: digits scanned; digit 0 is rightmost.
- `SCAN_DIV`, 100000: clock cycles per digit slot (≥ DEAD_CYCLES+2).
- `DEAD_CYCLES`, 2: cycles at slot start with all anodes off.
- `BLINK_FRAMES`, 64: frames per blink phase (≥ 1).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle request to replace the frame buffer with `digits_in`.
- `digits_in`  in  5*NUM_DIGITS  digit i at bits [5i+4:5i]; bit 4 is dp, bits [3:0] are the value (10–15 means blank).
- `blink_mask`  in  NUM_DIGITS  digit i blanks during the off phase when its bit is set; sampled live.
- `lzs_en`  in  1  leading-zero suppression enable; sampled live.
- `dec_data`  out  5  code to `seven_seg_dec`.
- `anodes`  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- `load_ack`  out  1  one-cycle pulse: the pending load has been applied to the frame buffer.
- `frame_done`  out  1  one-cycle pulse when the digit index wraps from NUM_DIGITS-1 to 0.

## Operation
- Blank code is 5'b01111.
- State:
  - prescaler `cnt` counts 0..SCAN_DIV-1.
  - digit index `idx` counts 0..NUM_DIGITS-1.
  - frame buffer `shadow`, pending buffer `pend` with flag `pend_v`.
  - frame counter 0..BLINK_FRAMES-1 and blink phase bit `ph`.
- Slot tick: `cnt==SCAN_DIV-1`. On a tick, `cnt`→0 and `idx` increments. When `idx==NUM_DIGITS-1`, it wraps to 0 (boundary tick).
- Boundary tick:
  - `frame_done` pulses.
  - The frame counter increments. On wrap it toggles `ph`.
  - If `pend_v`, then `shadow`←`pend`, `pend_v`←0, and `load_ack` pulses.
- `load` handling:
  - `load` captures `digits_in` into `pend` and sets `pend_v`.
  - A repeat `load` while pending overwrites `pend`; latest wins, and only one ack is issued.
  - `load` on a boundary tick: `digits_in` goes directly into `shadow`, `pend_v` is cleared, and `load_ack` pulses.
- Effective code for digit `idx`, in priority order:
  1. Blink: blank if `blink_mask[idx]` and `ph==1`.
  2. Suppression: blank if `lzs_en`, `idx≠0`, and every digit j≥idx has code 5'b00000 (value 0, dp clear).
  3. Otherwise the `shadow` code for `idx`.
- Anodes: all 1 while `cnt<DEAD_CYCLES`; otherwise `~(1<<idx)`.
- `dec_data` = effective code for `idx`, and it changes only while anodes are all off.
- Outputs are registered: in cycle t+1 they reflect `cnt`, `idx`, `shadow`, `ph` and the live inputs of cycle t.
- Reset (the cycle after `rst` high):
  - `cnt`=0, `idx`=0, frame counter 0, `ph`=0, `pend_v`=0, `shadow` all blank codes.
  - Outputs: `anodes`=all 1, `dec_data`=5'b01111, `load_ack`=0, `frame_done`=0.
- `rst` mid-frame discards any pending load without an ack.

## Timing
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS·SCAN_DIV cycles. Blink half-period is BLINK_FRAMES frames.
- `load`-to-`load_ack` latency: from 1 cycle (load on a boundary tick) up to one frame.
- `load_ack` and `frame_done` are asserted in the same cycle, one cycle after the boundary tick.
- The first frame after reset starts at digit 0, with `cnt`=0 in the first cycle after reset.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=6, DEAD_CYCLES=2, BLINK_FRAMES=2.

1. Reset, then idle 48 cycles.
   - `anodes` sequence per slot: 1111,1111,1110×4 / 1111,1111,1101×4 / 1011 / 0111.
   - `dec_data`=5'b01111 throughout.
   - `frame_done` pulses every 24 cycles.
2. `load` with codes {d3..d0}={00001,10010,00011,00100} mid-frame.
   - `dec_data` is unchanged until the boundary.
   - `load_ack` pulses with `frame_done`.
   - The next frame shows 00100, 00011, 10010, 00001 on anodes 1110, 1101, 1011, 0111.
3. Two `load`s in one frame (second one: all 00111).
   - Exactly one `load_ack`.
   - The next frame shows 00111 on every digit.
4. `lzs_en`=1 with codes {00000,00000,00101,00000}.
   - Digits 3 and 2 show 01111; digit 1 shows 00101; digit 0 shows 00000.
   - With code {00000,10000,00000,00000}, digit 3 only is blanked (the dp makes digit 2 nonzero).
5. `blink_mask`=0001 with digit 0 = 01000.
   - Digit 0 shows 01000 for 2 frames, then 01111 for 2 frames, repeating.
   - The other digits are unaffected.
6. `load` asserted on the boundary-tick cycle.
   - `load_ack` follows the next cycle, and the new data appears in that frame.
   - Separately, `rst` during pending: no `load_ack`, and the display stays blank.
